// File: rtl/boxhead_gfx_pkg.sv
// Shared graphics constants, the queued blit command and the blitter FSM states.
// No logic lives here; widths of blit_cmd_t set the blitter's default parameters.
package boxhead_gfx_pkg;

    localparam int          SCREEN_W    = 640;
    localparam int          SCREEN_H    = 480;
    localparam logic [9:0]  PARK_X      = 10'd1023;
    localparam logic [15:0] KEY_COLOR   = 16'hF81F;
    localparam int          BLIT_SPR_AW = 14;
    localparam int          BLIT_DIM_W  = 6;

    typedef struct packed {
        logic [9:0]             x;
        logic [9:0]             y;
        logic [BLIT_DIM_W-1:0]  w;
        logic [BLIT_DIM_W-1:0]  h;
        logic [BLIT_SPR_AW-1:0] base;
    } blit_cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FETCH,
        ST_CHECK,
        ST_PRESENT
    } blit_state_e;

endpackage

// File: rtl/blit_cmd_fifo.sv
// Show-ahead command FIFO: head visible same cycle, push/pop honoured together, flush empties it.
// Zero read latency; caller must not push when full_o (no internal overflow guard beyond that).
module blit_cmd_fifo
    import boxhead_gfx_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      flush_i,
    input  logic      push_i,
    input  blit_cmd_t push_dat_i,
    input  logic      pop_i,
    output blit_cmd_t pop_dat_o,
    output logic      empty_o,
    output logic      full_o
);

    localparam int AW = $clog2(DEPTH);

    blit_cmd_t     mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   cnt_q;
    logic          push_ok, pop_ok;

    assign empty_o   = (cnt_q == '0);
    assign full_o    = (cnt_q == (AW+1)'(DEPTH));
    assign pop_dat_o = mem_q[rd_ptr_q];
    assign push_ok   = push_i && !full_o;
    assign pop_ok    = pop_i && !empty_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push_ok && !pop_ok)      cnt_q <= cnt_q + (AW+1)'(1);
            else if (pop_ok && !push_ok) cnt_q <= cnt_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok && !flush_i) mem_q[wr_ptr_q] <= push_dat_i;
    end

endmodule

// File: rtl/sprite_blitter.sv
// Sprite blitter: pops draw commands, reads sprite ROM, drops keyed/off-screen pixels, offers one pixel per wr_slot.
// Accept->first fetch 2 cycles, fetch->present 2 cycles; cmd_ready low when the queue is full or in a flush cycle.
module sprite_blitter
    import boxhead_gfx_pkg::*;
#(
    parameter int SPR_AW     = BLIT_SPR_AW,
    parameter int DIM_W      = BLIT_DIM_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              sram_clk,
    input  logic              reset_n,
    input  logic              frame_clk,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [9:0]        cmd_x,
    input  logic [9:0]        cmd_y,
    input  logic [DIM_W-1:0]  cmd_w,
    input  logic [DIM_W-1:0]  cmd_h,
    input  logic [SPR_AW-1:0] cmd_base,
    output logic [SPR_AW-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    input  logic              wr_slot,
    output logic [9:0]        program_x,
    output logic [9:0]        program_y,
    output logic [15:0]       program_data,
    output logic              busy,
    output logic              overrun
);

    blit_state_e       state_q, state_d;
    logic [9:0]        x_q, x_d, y_q, y_d, px_q, px_d, py_q, py_d;
    logic [DIM_W-1:0]  w_q, w_d, h_q, h_d, col_q, col_d, row_q, row_d;
    logic [SPR_AW-1:0] ptr_q, ptr_d;
    logic [15:0]       pd_q, pd_d;
    logic              frame_q, flush_q, overrun_q;
    logic              frame_rise, fifo_empty, fifo_full, push, pop;
    logic              col_wrap, last_px, skip, adv;
    logic [10:0]       sx, sy;
    blit_cmd_t         push_dat, head;

    assign frame_rise   = frame_clk && !frame_q;
    assign cmd_ready    = !fifo_full && !flush_q;
    assign push         = cmd_valid && cmd_ready;
    assign pop          = (state_q == ST_LOAD) && !flush_q;
    assign busy         = !fifo_empty || (state_q != ST_IDLE);
    assign overrun      = overrun_q;
    assign rom_addr     = ptr_q;
    assign program_x    = px_q;
    assign program_y    = py_q;
    assign program_data = pd_q;

    assign push_dat = '{x: cmd_x, y: cmd_y, w: cmd_w, h: cmd_h, base: cmd_base};

    blit_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i      (sram_clk),
        .rst_ni     (reset_n),
        .flush_i    (flush_q),
        .push_i     (push),
        .push_dat_i (push_dat),
        .pop_i      (pop),
        .pop_dat_o  (head),
        .empty_o    (fifo_empty),
        .full_o     (fifo_full)
    );

    // 11-bit sums so coordinates wrapping past 1023 still count as off-screen
    assign sx       = 11'(x_q) + 11'(col_q);
    assign sy       = 11'(y_q) + 11'(row_q);
    assign skip     = (rom_data == KEY_COLOR) || (sx >= 11'(SCREEN_W)) || (sy >= 11'(SCREEN_H));
    assign col_wrap = (col_q == w_q - DIM_W'(1));
    assign last_px  = col_wrap && (row_q == h_q - DIM_W'(1));

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        w_d     = w_q;
        h_d     = h_q;
        col_d   = col_q;
        row_d   = row_q;
        ptr_d   = ptr_q;
        px_d    = px_q;
        py_d    = py_q;
        pd_d    = pd_q;
        adv     = 1'b0;
        case (state_q)
            ST_IDLE: if (!fifo_empty) state_d = ST_LOAD;
            ST_LOAD: begin
                x_d     = head.x;
                y_d     = head.y;
                w_d     = head.w;
                h_d     = head.h;
                col_d   = '0;
                row_d   = '0;
                ptr_d   = head.base;
                state_d = (head.w == '0 || head.h == '0) ? ST_IDLE : ST_FETCH;
            end
            ST_FETCH: state_d = ST_CHECK;
            ST_CHECK: begin
                if (skip) begin
                    adv     = 1'b1;
                    state_d = last_px ? ST_IDLE : ST_FETCH;
                end else begin
                    px_d    = sx[9:0];
                    py_d    = sy[9:0];
                    pd_d    = rom_data;
                    state_d = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (wr_slot) begin
                    px_d    = PARK_X;
                    py_d    = '0;
                    pd_d    = '0;
                    adv     = 1'b1;
                    state_d = last_px ? ST_IDLE : ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (adv) begin
            ptr_d = ptr_q + SPR_AW'(1);
            if (col_wrap) begin
                col_d = '0;
                row_d = row_q + DIM_W'(1);
            end else begin
                col_d = col_q + DIM_W'(1);
            end
        end
        // A frame edge abandons whatever was in flight
        if (flush_q) begin
            state_d = ST_IDLE;
            px_d    = PARK_X;
            py_d    = '0;
            pd_d    = '0;
        end
    end

    always_ff @(posedge sram_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            x_q       <= '0;
            y_q       <= '0;
            w_q       <= '0;
            h_q       <= '0;
            col_q     <= '0;
            row_q     <= '0;
            ptr_q     <= '0;
            px_q      <= PARK_X;
            py_q      <= '0;
            pd_q      <= '0;
            frame_q   <= 1'b0;
            flush_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            w_q       <= w_d;
            h_q       <= h_d;
            col_q     <= col_d;
            row_q     <= row_d;
            ptr_q     <= ptr_d;
            px_q      <= px_d;
            py_q      <= py_d;
            pd_q      <= pd_d;
            frame_q   <= frame_clk;
            flush_q   <= frame_rise;
            overrun_q <= frame_rise && busy;
        end
    end

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter: ROM model, slot generator and write monitor around a linear stimulus sequence.
module tb_sprite_blitter;
    import boxhead_gfx_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        frame_clk = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [9:0]  cmd_x = '0, cmd_y = '0;
    logic [5:0]  cmd_w = '0, cmd_h = '0;
    logic [13:0] cmd_base = '0;
    logic [13:0] rom_addr;
    logic [15:0] rom_data = '0;
    logic        wr_slot = 1'b0;
    logic [9:0]  program_x, program_y;
    logic [15:0] program_data;
    logic        busy, overrun;

    logic [15:0]  rom [256];
    logic         slot_en = 1'b0;
    int           nwr = 0;
    logic [47:0]  wlog [16];
    logic [255:0] seen = '0;
    int           tests = 0;
    int           fails = 0;

    always #5 clk = ~clk;

    sprite_blitter dut (
        .sram_clk     (clk),
        .reset_n      (reset_n),
        .frame_clk    (frame_clk),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_x        (cmd_x),
        .cmd_y        (cmd_y),
        .cmd_w        (cmd_w),
        .cmd_h        (cmd_h),
        .cmd_base     (cmd_base),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .wr_slot      (wr_slot),
        .program_x    (program_x),
        .program_y    (program_y),
        .program_data (program_data),
        .busy         (busy),
        .overrun      (overrun)
    );

    always @(posedge clk) rom_data <= rom[rom_addr[7:0]];

    // Record every on-screen write the controller would latch, plus every ROM address presented
    always @(posedge clk) begin
        if (wr_slot && program_x != PARK_X) begin
            if (nwr < 16) wlog[nwr] = {6'd0, program_x, program_y, program_data};
            nwr = nwr + 1;
        end
        seen[rom_addr[7:0]] = 1'b1;
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            wr_slot = slot_en ? ~wr_slot : 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [9:0] x, input logic [9:0] y, input logic [5:0] w,
                        input logic [5:0] h, input logic [13:0] base);
        cmd_x = x; cmd_y = y; cmd_w = w; cmd_h = h; cmd_base = base;
        cmd_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (cmd_ready) begin
                tick();
                cmd_valid = 1'b0;
                return;
            end
            tick();
        end
        cmd_valid = 1'b0;
        chk("send_timeout", 48'd0, 48'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            tick();
            if (!busy) return;
        end
        chk("idle_timeout", {47'd0, busy}, 48'd0);
    endtask

    function automatic logic [47:0] px(input logic [9:0] x, input logic [9:0] y, input logic [15:0] d);
        return {6'd0, x, y, d};
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
        rom[8'h10] = 16'h1111; rom[8'h11] = 16'h2222; rom[8'h12] = 16'h3333; rom[8'h13] = 16'h4444;
        rom[8'h20] = 16'h5555; rom[8'h21] = 16'h6666; rom[8'h22] = 16'h7777; rom[8'h23] = 16'h8888;
        for (int i = 0; i < 16; i++) rom[8'h40 + i] = 16'h0100 + 16'(i);

        // Asynchronous reset, checked before any clock edge
        #2 reset_n = 1'b0;
        #1;
        chk("rst_px", program_x, PARK_X);
        chk("rst_py", program_y, 0);
        chk("rst_pd", program_data, 0);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_rom", rom_addr, 0);
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        chk("post_rst_px", program_x, PARK_X);
        chk("post_rst_ready", cmd_ready, 1);
        chk("post_rst_busy", busy, 0);

        // 2x2 sprite at (100,50), all opaque
        slot_en = 1'b1;
        nwr = 0; seen = '0;
        send(10'd100, 10'd50, 6'd2, 6'd2, 14'h10);
        chk("lat_accept_rom", rom_addr, 0);
        chk("lat_accept_busy", busy, 1);
        tick();
        chk("lat_load_rom", rom_addr, 0);
        tick();
        chk("lat_fetch_rom", rom_addr, 14'h10);
        wait_idle();
        chk("s1_nwr", nwr, 4);
        chk("s1_w0", wlog[0], px(10'd100, 10'd50, 16'h1111));
        chk("s1_w1", wlog[1], px(10'd101, 10'd50, 16'h2222));
        chk("s1_w2", wlog[2], px(10'd100, 10'd51, 16'h3333));
        chk("s1_w3", wlog[3], px(10'd101, 10'd51, 16'h4444));
        chk("s1_seen", seen[8'h13:8'h10], 4'hF);
        chk("s1_ptr", rom_addr, 14'h14);
        chk("s1_park", {program_x, program_y, program_data}, {PARK_X, 10'd0, 16'd0});

        // Same sprite with the second pixel keyed out
        rom[8'h11] = KEY_COLOR;
        nwr = 0; seen = '0;
        send(10'd100, 10'd50, 6'd2, 6'd2, 14'h10);
        wait_idle();
        chk("s2_nwr", nwr, 3);
        chk("s2_w0", wlog[0], px(10'd100, 10'd50, 16'h1111));
        chk("s2_w1", wlog[1], px(10'd100, 10'd51, 16'h3333));
        chk("s2_w2", wlog[2], px(10'd101, 10'd51, 16'h4444));
        chk("s2_seen", seen[8'h13:8'h10], 4'hF);
        chk("s2_ptr", rom_addr, 14'h14);

        // Right/bottom clipping and a sprite entirely past x=1023
        nwr = 0;
        send(10'd638, 10'd479, 6'd3, 6'd1, 14'h20);
        wait_idle();
        chk("s3_nwr", nwr, 2);
        chk("s3_w0", wlog[0], px(10'd638, 10'd479, 16'h5555));
        chk("s3_w1", wlog[1], px(10'd639, 10'd479, 16'h6666));
        chk("s3_ptr", rom_addr, 14'h23);
        nwr = 0;
        send(10'd1023, 10'd0, 6'd1, 6'd1, 14'h23);
        wait_idle();
        chk("s4_nwr", nwr, 0);
        chk("s4_ptr", rom_addr, 14'h24);

        // Zero-size command is consumed without touching the ROM
        send(10'd5, 10'd5, 6'd0, 6'd3, 14'h30);
        wait_idle();
        chk("s4_empty_ptr", rom_addr, 14'h30);

        // Queue fill with no slots: ready drops, first pixel is held
        slot_en = 1'b0;
        repeat (3) tick();
        nwr = 0;
        for (int i = 0; i < 5; i++) send(10'd0, 10'd0, 6'd2, 6'd2, 14'h10);
        chk("q_ready_low", cmd_ready, 0);
        chk("q_busy", busy, 1);
        repeat (20) tick();
        chk("q_hold", {program_x, program_y, program_data}, {10'd0, 10'd0, 16'h1111});
        chk("q_nwr", nwr, 0);
        chk("q_ready_still", cmd_ready, 0);

        // Frame edge flushes the full queue
        frame_clk = 1'b1;
        tick();
        chk("f1_ovr", overrun, 1);
        chk("f1_ready_flush", cmd_ready, 0);
        tick();
        chk("f1_ovr_end", overrun, 0);
        chk("f1_busy", busy, 0);
        chk("f1_park", {program_x, program_y, program_data}, {PARK_X, 10'd0, 16'd0});
        chk("f1_ready", cmd_ready, 1);
        frame_clk = 1'b0;
        repeat (2) tick();

        // Frame edge during the second pixel of a 4x4 with two more commands queued
        slot_en = 1'b1;
        nwr = 0;
        send(10'd10, 10'd20, 6'd4, 6'd4, 14'h40);
        send(10'd5, 10'd5, 6'd1, 6'd1, 14'h20);
        send(10'd6, 10'd6, 6'd1, 6'd1, 14'h21);
        for (int i = 0; i < 100 && nwr < 1; i++) tick();
        chk("f2_first_write", nwr, 1);
        frame_clk = 1'b1;
        tick();
        chk("f2_ovr", overrun, 1);
        tick();
        chk("f2_ovr_end", overrun, 0);
        chk("f2_busy", busy, 0);
        chk("f2_park_x", program_x, PARK_X);
        frame_clk = 1'b0;
        repeat (20) tick();
        chk("f2_nwr", nwr, 1);
        chk("f2_w0", wlog[0], px(10'd10, 10'd20, 16'h0100));
        chk("f2_busy_late", busy, 0);
        chk("f2_ovr_late", overrun, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
